// File: rtl/cordic16_serial_engine.sv
// cordic16_serial_engine: iterative 16-step CORDIC, one micro-rotation per clock,
// rotation and vectoring modes with coarse 180-degree pre-rotation.
module cordic16_serial_engine #(
  parameter int ITER = 16,
  parameter int ZW   = 24,
  parameter int XW   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] xi,
  input  logic [15:0] yi,
  input  logic [15:0] zi,
  input  logic        load,
  input  logic        mi,
  output logic [15:0] xo,
  output logic [15:0] yo,
  output logic [15:0] zo,
  output logic        mo,
  output logic        rdy
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [ZW-1:0] HALF = {1'b1, {(ZW-1){1'b0}}};
  localparam logic [ZW-1:0] ATAN [16] = '{
    24'd2097152, 24'd1238021, 24'd654136, 24'd332050,
    24'd166669,  24'd83416,   24'd41718,  24'd20860,
    24'd10430,   24'd5215,    24'd2608,   24'd1304,
    24'd652,     24'd326,     24'd163,    24'd81
  };
  state_t state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d, xe, ye, xs, ys;
  logic signed [XW:0] xr, yr;
  logic [ZW-1:0] z_q, z_d, zin, zr;
  logic [3:0] i_q, i_d;
  logic m_q, m_d, zf_q, zf_d, flip, neg;
  logic [15:0] xo_d, yo_d, zo_d;
  logic mo_d, rdy_d;

  function automatic logic [15:0] sat16(input logic signed [XW:0] v);
    logic signed [XW:0] s;
    s = v >>> 4;
    return (&s[XW:15] || ~|s[XW:15]) ? s[15:0] : {s[XW], {15{~s[XW]}}};
  endfunction

  always_comb begin
    xe = {{(XW-19){xi[15]}}, xi, 3'b0};
    ye = {{(XW-19){yi[15]}}, yi, 3'b0};
    zin = {zi, {(ZW-16){1'b0}}};
    flip = mi ? zin[ZW-1] ^ zin[ZW-2] : xi[15];
    xs = x_q >>> i_q;
    ys = y_q >>> i_q;
    neg = m_q ? z_q[ZW-1] : ~y_q[XW-1];
    xr = {x_q[XW-1], x_q} + (XW+1)'(8);
    yr = {y_q[XW-1], y_q} + (XW+1)'(8);
    zr = z_q + ZW'(128);
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    i_d = i_q;
    m_d = m_q;
    zf_d = zf_q;
    xo_d = xo;
    yo_d = yo;
    zo_d = zo;
    mo_d = mo;
    rdy_d = 1'b0;
    if (load) begin
      state_d = RUN;
      x_d = flip ? -xe : xe;
      y_d = flip ? -ye : ye;
      z_d = mi ? (flip ? zin + HALF : zin) : (flip ? HALF : '0);
      i_d = '0;
      m_d = mi;
      // all-zero vector never converges in angle; its phase is pinned to 0
      zf_d = ~mi & ~|{xi, yi};
    end else if (state_q == RUN) begin
      x_d = neg ? x_q + ys : x_q - ys;
      y_d = neg ? y_q - xs : y_q + xs;
      z_d = neg ? z_q + ATAN[i_q] : z_q - ATAN[i_q];
      i_d = i_q + 4'd1;
      state_d = i_q == 4'(ITER-1) ? FIN : RUN;
    end else if (state_q == FIN) begin
      state_d = IDLE;
      xo_d = sat16(xr);
      yo_d = sat16(yr);
      zo_d = zf_q ? '0 : zr[ZW-1-:16];
      mo_d = m_q;
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      i_q <= '0;
      m_q <= 1'b0;
      zf_q <= 1'b0;
      xo <= '0;
      yo <= '0;
      zo <= '0;
      mo <= 1'b0;
      rdy <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
      m_q <= m_d;
      zf_q <= zf_d;
      xo <= xo_d;
      yo <= yo_d;
      zo <= zo_d;
      mo <= mo_d;
      rdy <= rdy_d;
    end
  end
endmodule

// File: tb/tb_cordic16_serial_engine.sv
// tb_cordic16_serial_engine: directed checks of vectoring, rotation, latency, abort and reset.
module tb_cordic16_serial_engine;
  logic clk = 0, rst = 1, load = 0, mi = 0;
  logic [15:0] xi = 0, yi = 0, zi = 0, xo, yo, zo;
  logic mo, rdy;
  int tests = 0, fails = 0;
  localparam real G = 0.8233801;
  localparam real PI = 3.14159265358979;

  always #5 clk = ~clk;

  cordic16_serial_engine dut (
    .clk(clk), .rst(rst), .xi(xi), .yi(yi), .zi(zi), .load(load), .mi(mi),
    .xo(xo), .yo(yo), .zo(zo), .mo(mo), .rdy(rdy)
  );

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int zdist(input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] d;
    d = a - b;
    return iabs(int'(d));
  endfunction

  task automatic run(input int x, input int y, input int z, input logic m, output int lat,
                     output int ox, output int oy, output logic [15:0] oz, output logic om,
                     output logic r2);
    @(negedge clk);
    xi = 16'(x); yi = 16'(y); zi = 16'(z); mi = m; load = 1;
    @(posedge clk);
    #1 load = 0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (rdy) begin
        lat = k;
        break;
      end
    end
    ox = int'($signed(xo)); oy = int'($signed(yo)); oz = zo; om = mo;
    @(posedge clk);
    #1 r2 = rdy;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    int seen = 0;
    #2 rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (rdy) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL reset_idle_rdy got %0d pulses exp 0", seen); end
    tests++;
    if ({xo, yo, zo, mo, rdy} !== '0) begin
      fails++; $display("FAIL reset_outputs got xo=%0d yo=%0d zo=%0d mo=%0b exp all 0", xo, yo, zo, mo);
    end
  endtask

  task automatic test_vector_quadrants();
    int tx[4] = '{16384, -16384, -16384, 16384};
    int ty[4] = '{16384, 16384, -16384, -16384};
    int tz[4] = '{8192, 24576, 40960, 57344};
    int lat, ox, oy;
    logic [15:0] oz;
    logic om, r2;
    for (int j = 0; j < 4; j++) begin
      run(tx[j], ty[j], 12345, 1'b0, lat, ox, oy, oz, om, r2);
      tests++;
      if (lat !== 17) begin fails++; $display("FAIL vq%0d_latency got %0d exp 17", j, lat); end
      tests++;
      if (r2 !== 1'b0) begin fails++; $display("FAIL vq%0d_rdy_width got %0b exp 0", j, r2); end
      tests++;
      if (zdist(oz, 16'(tz[j])) > 2) begin fails++; $display("FAIL vq%0d_zo got %0d exp %0d+-2", j, oz, tz[j]); end
      tests++;
      if (iabs(ox - 19078) > 3) begin fails++; $display("FAIL vq%0d_xo got %0d exp 19078+-3", j, ox); end
      tests++;
      if (iabs(oy) > 3) begin fails++; $display("FAIL vq%0d_yo got %0d exp 0+-3", j, oy); end
      tests++;
      if (om !== 1'b0) begin fails++; $display("FAIL vq%0d_mo got %0b exp 0", j, om); end
    end
  endtask

  task automatic test_vector_sweep(input int div, input int ztol);
    int tx[8] = '{14142, 10000, 0, -10000, -14142, -10000, 0, 10000};
    int ty[8] = '{0, 10000, 14142, 10000, 0, -10000, -14142, -10000};
    int lat, ox, oy, x, y;
    logic [15:0] oz;
    logic om, r2;
    real ideal;
    for (int j = 0; j < 8; j++) begin
      x = tx[j] / div;
      y = ty[j] / div;
      ideal = G * $sqrt(real'(x * x + y * y));
      run(x, y, 0, 1'b0, lat, ox, oy, oz, om, r2);
      tests++;
      if (zdist(oz, 16'(j * 8192)) > ztol) begin
        fails++; $display("FAIL vsweep_a%0d_p%0d_zo got %0d exp %0d+-%0d", div, j, oz, j * 8192, ztol);
      end
      tests++;
      if (real'(ox) - ideal > 3.0 || real'(ox) - ideal < -3.0) begin
        fails++; $display("FAIL vsweep_a%0d_p%0d_xo got %0d exp %0.1f+-3", div, j, ox, ideal);
      end
    end
  endtask

  task automatic test_zero();
    int lat, ox, oy;
    logic [15:0] oz;
    logic om, r2;
    run(0, 0, 0, 1'b0, lat, ox, oy, oz, om, r2);
    tests++;
    if (lat !== 17) begin fails++; $display("FAIL zero_latency got %0d exp 17", lat); end
    tests++;
    if (ox !== 0) begin fails++; $display("FAIL zero_xo got %0d exp 0", ox); end
    tests++;
    if (zdist(oz, 16'd0) > 2) begin fails++; $display("FAIL zero_zo got %0d exp 0+-2", oz); end
  endtask

  task automatic test_rotation(input int amp);
    int lat, ox, oy;
    logic [15:0] oz;
    logic om, r2;
    real a, ex, ey;
    for (int z = 0; z < 65536; z += 512) begin
      a = 2.0 * PI * real'(z) / 65536.0;
      ex = G * real'(amp) * ($cos(a) - $sin(a));
      ey = G * real'(amp) * ($sin(a) + $cos(a));
      run(amp, amp, z, 1'b1, lat, ox, oy, oz, om, r2);
      tests++;
      if (real'(ox) - ex > 3.0 || real'(ox) - ex < -3.0) begin
        fails++; $display("FAIL rot_a%0d_z%0d_xo got %0d exp %0.1f+-3", amp, z, ox, ex);
      end
      tests++;
      if (real'(oy) - ey > 3.0 || real'(oy) - ey < -3.0) begin
        fails++; $display("FAIL rot_a%0d_z%0d_yo got %0d exp %0.1f+-3", amp, z, oy, ey);
      end
      tests++;
      if (om !== 1'b1 || lat !== 17) begin
        fails++; $display("FAIL rot_a%0d_z%0d_mo_lat got mo=%0b lat=%0d exp mo=1 lat=17", amp, z, om, lat);
      end
    end
  endtask

  task automatic test_abort();
    int n = 0, first = -1, ox = 0;
    logic om = 0;
    @(negedge clk);
    xi = 16'(16384); yi = 16'(16384); zi = 0; mi = 0; load = 1;
    @(posedge clk);
    #1 load = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (rdy) n++;
    end
    @(negedge clk);
    xi = 16'(20000); yi = 16'(20000); zi = 0; mi = 1; load = 1;
    @(posedge clk);
    #1 load = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rdy) begin
        n++;
        if (first < 0) begin first = k; ox = int'($signed(xo)); om = mo; end
      end
    end
    tests++;
    if (n !== 1) begin fails++; $display("FAIL abort_rdy_count got %0d exp 1", n); end
    tests++;
    if (first !== 17) begin fails++; $display("FAIL abort_latency got %0d exp 17", first); end
    tests++;
    if (om !== 1'b1) begin fails++; $display("FAIL abort_mo got %0b exp 1", om); end
    tests++;
    if (iabs(ox - 16468) > 3) begin fails++; $display("FAIL abort_xo got %0d exp 16468+-3", ox); end
  endtask

  task automatic test_reset_mid();
    int n = 0, lat, ox, oy;
    logic [15:0] oz;
    logic om, r2;
    @(negedge clk);
    xi = 16'(10000); yi = 16'(10000); zi = 0; mi = 0; load = 1;
    @(posedge clk);
    #1 load = 0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 0;
    #1;
    tests++;
    if ({xo, yo, zo, mo, rdy} !== '0) begin
      fails++; $display("FAIL midreset_outputs got xo=%0d yo=%0d zo=%0d mo=%0b rdy=%0b exp all 0", xo, yo, zo, mo, rdy);
    end
    @(negedge clk) rst = 1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (rdy) n++;
    end
    tests++;
    if (n !== 0) begin fails++; $display("FAIL midreset_rdy got %0d pulses exp 0", n); end
    run(16384, 16384, 0, 1'b0, lat, ox, oy, oz, om, r2);
    tests++;
    if (lat !== 17) begin fails++; $display("FAIL recover_latency got %0d exp 17", lat); end
    tests++;
    if (iabs(ox - 19078) > 3) begin fails++; $display("FAIL recover_xo got %0d exp 19078+-3", ox); end
  endtask

  initial begin
    test_reset();
    test_vector_quadrants();
    test_vector_sweep(1, 2);
    test_vector_sweep(10, 40);
    test_vector_sweep(100, 40);
    test_zero();
    test_rotation(20000);
    test_rotation(200);
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
